// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: the FSM state
// encoding, the default SRAM wait-state count and a counter-width helper.
package imem_dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_MEM  = 2'd2
  } arb_state_t;

  localparam int ARB_WAIT_CYCLES_DEF = 2;

  // Width of a counter that must hold values 0..wait_cycles
  function automatic int cnt_width(input int wait_cycles);
    return $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_wait_counter.sv
// Loadable down-counter used to time SRAM wait states. The owner decides
// when to decrement; the zero flag marks the final access cycle.
module wait_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  // Load takes precedence over decrement so a new access always starts clean
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-port fixed-latency SRAM between instruction
// fetch and data access. MEM has fixed priority over IF when both request
// in IDLE. Optional performance counters are enabled by ARB_PERF_CNT_EN.
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = ARB_WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_freeze,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_freeze,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_mem_acc
`endif
);

  localparam int CNT_W = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              cnt_load;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_zero;

  wait_counter #(
    .W(CNT_W)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_LOAD),
    .dec      (cnt_dec),
    .value    (cnt_val),
    .zero     (cnt_zero)
  );

  // Count down through every access cycle until the final one
  assign cnt_dec = (state != ARB_IDLE) && (cnt_val != '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the granted request in IDLE; held stable for the whole access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (state == ARB_IDLE) begin
      if (mem_req) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        we_q    <= mem_we;
      end else if (if_req && !if_flush) begin
        addr_q <= if_addr;
        we_q   <= 1'b0;
      end
    end
  end

  // Next-state decode, counter control and access handshakes
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    if_valid  = 1'b0;
    mem_ready = 1'b0;
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (mem_req) begin
          state_nxt = ARB_MEM;
          cnt_load  = 1'b1;
        end else if (if_req && !if_flush) begin
          state_nxt = ARB_IF;
          cnt_load  = 1'b1;
        end
      end
      ARB_IF: begin
        sram_en = 1'b1;
        if (if_flush) begin
          state_nxt = ARB_IDLE;
        end else if (cnt_zero) begin
          if_valid  = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      ARB_MEM: begin
        sram_en = 1'b1;
        sram_we = we_q;
        if (cnt_zero) begin
          mem_ready = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign if_rdata   = if_valid ? sram_rdata : '0;
  assign mem_rdata  = (mem_ready && !we_q) ? sram_rdata : '0;
  assign if_freeze  = if_req & ~if_valid & ~if_flush;
  assign mem_freeze = mem_req & ~mem_ready;

`ifdef ARB_PERF_CNT_EN
  // Free-running wrap-around counters of fetch stall cycles and data accesses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_stall <= '0;
      perf_mem_acc  <= '0;
    end else begin
      if (if_freeze) begin
        perf_if_stall <= perf_if_stall + 32'd1;
      end
      if (mem_ready) begin
        perf_mem_acc <= perf_mem_acc + 32'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration
`endif

endmodule
